// File: rtl/tinker_mem_hs.sv
// Byte-addressed big-endian memory with independent fetch and load/store ports.
// Each port runs IDLE -> WAIT -> RESP with a programmable response latency.
module tinker_mem_hs #(
  parameter int MEM_BYTES   = 524288,
  parameter int ADDR_W      = 32,
  parameter int INSTR_BYTES = 4,
  parameter int DATA_BYTES  = 8,
  parameter int LATENCY     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     f_req_valid,
  output logic                     f_req_ready,
  input  logic [ADDR_W-1:0]        f_addr,
  output logic                     f_resp_valid,
  input  logic                     f_resp_ready,
  output logic [8*INSTR_BYTES-1:0] f_resp_data,
  output logic                     f_resp_err,
  input  logic                     d_req_valid,
  output logic                     d_req_ready,
  input  logic                     d_we,
  input  logic [ADDR_W-1:0]        d_addr,
  input  logic [8*DATA_BYTES-1:0]  d_wdata,
  output logic                     d_resp_valid,
  input  logic                     d_resp_ready,
  output logic [8*DATA_BYTES-1:0]  d_resp_data,
  output logic                     d_resp_err,
  output logic [1:0]               o_f_state,
  output logic [1:0]               o_d_state
);

  // Handshake: a request is accepted at a clock edge where req_valid && req_ready;
  // a response is consumed at an edge where resp_valid && resp_ready. Requesters
  // must hold req_valid until accepted; nothing is buffered.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int MA_W  = $clog2(MEM_BYTES);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W+1)'(MEM_BYTES);

  logic [7:0] r_mem [MEM_BYTES];

  state_t                   r_f_state, r_d_state;
  logic [CNT_W-1:0]         r_f_cnt, r_d_cnt;
  logic                     r_f_ready, r_d_ready;
  logic                     r_f_valid, r_d_valid;
  logic [8*INSTR_BYTES-1:0] r_f_data;
  logic [8*DATA_BYTES-1:0]  r_d_data;
  logic                     r_f_err, r_d_err;

  logic                     w_f_acc, w_d_acc;
  logic                     w_f_err, w_d_err;
  logic [MA_W-1:0]          w_f_base, w_d_base;
  logic [8*INSTR_BYTES-1:0] w_f_rdata;
  logic [8*DATA_BYTES-1:0]  w_d_rdata;

  // Sum at ADDR_W+1 bits so an address near the top of the space cannot wrap into range.
  assign w_f_err  = ({1'b0, f_addr} + (ADDR_W+1)'(INSTR_BYTES)) > MEM_LIM;
  assign w_d_err  = ({1'b0, d_addr} + (ADDR_W+1)'(DATA_BYTES)) > MEM_LIM;
  assign w_f_base = f_addr[MA_W-1:0];
  assign w_d_base = d_addr[MA_W-1:0];
  assign w_f_acc  = f_req_valid & r_f_ready & ~reset;
  assign w_d_acc  = d_req_valid & r_d_ready & ~reset;

  always_comb begin
    w_f_rdata = '0;
    for (int i = 0; i < INSTR_BYTES; i++)
      w_f_rdata[8*(INSTR_BYTES-i)-1 -: 8] = r_mem[w_f_base + MA_W'(i)];
    if (w_f_err) w_f_rdata = '0;
  end

  always_comb begin
    w_d_rdata = '0;
    for (int i = 0; i < DATA_BYTES; i++)
      w_d_rdata[8*(DATA_BYTES-i)-1 -: 8] = r_mem[w_d_base + MA_W'(i)];
    if (w_d_err || d_we) w_d_rdata = '0;
  end

  // Reads above sample the pre-edge contents, so a same-edge fetch sees the old bytes.
  always_ff @(posedge clk) begin
    if (w_d_acc && d_we && !w_d_err) begin
      for (int i = 0; i < DATA_BYTES; i++)
        r_mem[w_d_base + MA_W'(i)] <= d_wdata[8*(DATA_BYTES-i)-1 -: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_f_state <= ST_IDLE;
      r_f_cnt   <= '0;
      r_f_ready <= 1'b0;
      r_f_valid <= 1'b0;
      r_f_data  <= '0;
      r_f_err   <= 1'b0;
    end else begin
      case (r_f_state)
        ST_IDLE: begin
          r_f_ready <= 1'b1;
          if (w_f_acc) begin
            r_f_ready <= 1'b0;
            r_f_data  <= w_f_rdata;
            r_f_err   <= w_f_err;
            if (LATENCY == 1) begin
              r_f_state <= ST_RESP;
              r_f_valid <= 1'b1;
            end else begin
              r_f_state <= ST_WAIT;
              r_f_cnt   <= CNT_W'(LATENCY-1);
            end
          end
        end
        ST_WAIT: begin
          r_f_cnt <= r_f_cnt - CNT_W'(1);
          if (r_f_cnt == CNT_W'(1)) begin
            r_f_state <= ST_RESP;
            r_f_valid <= 1'b1;
          end
        end
        ST_RESP: begin
          if (f_resp_ready) begin
            r_f_state <= ST_IDLE;
            r_f_valid <= 1'b0;
            r_f_ready <= 1'b1;
          end
        end
        default: r_f_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_d_state <= ST_IDLE;
      r_d_cnt   <= '0;
      r_d_ready <= 1'b0;
      r_d_valid <= 1'b0;
      r_d_data  <= '0;
      r_d_err   <= 1'b0;
    end else begin
      case (r_d_state)
        ST_IDLE: begin
          r_d_ready <= 1'b1;
          if (w_d_acc) begin
            r_d_ready <= 1'b0;
            r_d_data  <= w_d_rdata;
            r_d_err   <= w_d_err;
            if (LATENCY == 1) begin
              r_d_state <= ST_RESP;
              r_d_valid <= 1'b1;
            end else begin
              r_d_state <= ST_WAIT;
              r_d_cnt   <= CNT_W'(LATENCY-1);
            end
          end
        end
        ST_WAIT: begin
          r_d_cnt <= r_d_cnt - CNT_W'(1);
          if (r_d_cnt == CNT_W'(1)) begin
            r_d_state <= ST_RESP;
            r_d_valid <= 1'b1;
          end
        end
        ST_RESP: begin
          if (d_resp_ready) begin
            r_d_state <= ST_IDLE;
            r_d_valid <= 1'b0;
            r_d_ready <= 1'b1;
          end
        end
        default: r_d_state <= ST_IDLE;
      endcase
    end
  end

  assign f_req_ready  = r_f_ready;
  assign f_resp_valid = r_f_valid;
  assign f_resp_data  = r_f_data;
  assign f_resp_err   = r_f_err;
  assign d_req_ready  = r_d_ready;
  assign d_resp_valid = r_d_valid;
  assign d_resp_data  = r_d_data;
  assign d_resp_err   = r_d_err;
  assign o_f_state    = r_f_state;
  assign o_d_state    = r_d_state;

endmodule

// File: tb/tb_tinker_mem_hs.sv
// Directed bench for tinker_mem_hs: latency, big-endian layout, range errors,
// response back-pressure, same-edge read-before-write and reset mid-transaction.
module tb_tinker_mem_hs;
  localparam int MEM_BYTES = 524288;
  localparam int LAT       = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        f_req_valid = 1'b0, f_resp_ready = 1'b0;
  logic [31:0] f_addr = '0;
  logic        f_req_ready, f_resp_valid, f_resp_err;
  logic [31:0] f_resp_data;
  logic        d_req_valid = 1'b0, d_we = 1'b0, d_resp_ready = 1'b0;
  logic [31:0] d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic        d_req_ready, d_resp_valid, d_resp_err;
  logic [63:0] d_resp_data;
  logic [1:0]  o_f_state, o_d_state;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  tinker_mem_hs #(.MEM_BYTES(MEM_BYTES), .ADDR_W(32), .INSTR_BYTES(4),
                  .DATA_BYTES(8), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_addr(f_addr),
    .f_resp_valid(f_resp_valid), .f_resp_ready(f_resp_ready),
    .f_resp_data(f_resp_data), .f_resp_err(f_resp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_resp_valid(d_resp_valid),
    .d_resp_ready(d_resp_ready), .d_resp_data(d_resp_data), .d_resp_err(d_resp_err),
    .o_f_state(o_f_state), .o_d_state(o_d_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Data-port transaction; entered and left at a negedge. hold = cycles to stall resp_ready.
  task automatic d_txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [63:0] wd, input int hold,
                       output logic [63:0] rd, output logic er);
    int n;
    d_req_valid = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
    d_resp_ready = (hold == 0);
    n = 0;
    while (d_req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_rdy"}, 64'(d_req_ready), 64'd1);
    @(negedge clk);
    d_req_valid = 1'b0;
    n = 1;
    while (d_resp_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_lat"}, 64'(n), 64'(LAT));
    rd = d_resp_data; er = d_resp_err;
    if (hold > 0) begin
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        chk({tag, "_hold_data"}, d_resp_data, rd);
        chk({tag, "_hold_flags"}, 64'({d_resp_valid, d_req_ready, d_resp_err}),
            64'({1'b1, 1'b0, er}));
      end
      d_resp_ready = 1'b1;
    end
    @(negedge clk);
    chk({tag, "_done"}, 64'({d_resp_valid, d_req_ready}), 64'b01);
    d_resp_ready = 1'b0;
  endtask

  task automatic f_txn(input string tag, input logic [31:0] addr,
                       output logic [31:0] rd, output logic er);
    int n;
    f_req_valid = 1'b1; f_addr = addr; f_resp_ready = 1'b1;
    n = 0;
    while (f_req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_rdy"}, 64'(f_req_ready), 64'd1);
    @(negedge clk);
    f_req_valid = 1'b0;
    n = 1;
    while (f_resp_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_lat"}, 64'(n), 64'(LAT));
    rd = f_resp_data; er = f_resp_err;
    @(negedge clk);
    chk({tag, "_done"}, 64'({f_resp_valid, f_req_ready}), 64'b01);
    f_resp_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] rd;
    logic [31:0] frd;
    logic        er, fer, seen;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'({f_req_ready, d_req_ready}), 64'b00);
    chk("rst_valid", 64'({f_resp_valid, d_resp_valid, f_resp_err, d_resp_err}), 64'b0);
    chk("rst_fdata", 64'(f_resp_data), 64'd0);
    chk("rst_ddata", d_resp_data, 64'd0);
    chk("rst_state", 64'({o_f_state, o_d_state}), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rel_ready", 64'({f_req_ready, d_req_ready}), 64'b11);

    // store then load, latency and big-endian layout
    d_txn("st100", 1'b1, 32'h100, 64'h0123456789ABCDEF, 0, rd, er);
    chk("st100_data", 64'({er, rd}), 64'd0);
    exp_q.push_back(64'h0123456789ABCDEF);
    d_txn("ld100", 1'b0, 32'h100, 64'h0, 0, rd, er);
    chk("ld100_data", rd, exp_q.pop_front());
    chk("ld100_err", 64'(er), 64'd0);

    // unaligned fetch
    f_txn("f102", 32'h102, frd, fer);
    chk("f102_data", 64'(frd), 64'h456789AB);
    chk("f102_err", 64'(fer), 64'd0);

    // range boundaries
    d_txn("ld_hi", 1'b0, MEM_BYTES - 4, 64'h0, 0, rd, er);
    chk("ld_hi_res", 64'(er), 64'd1);
    chk("ld_hi_data", rd, 64'd0);
    d_txn("st_top", 1'b1, MEM_BYTES - 8, 64'h1122334455667788, 0, rd, er);
    chk("st_top_err", 64'(er), 64'd0);
    d_txn("st_0", 1'b1, 32'h0, 64'hA1A2A3A4A5A6A7A8, 0, rd, er);
    d_txn("st_wrap", 1'b1, 32'hFFFFFFFC, 64'h5555555555555555, 0, rd, er);
    chk("st_wrap_err", 64'(er), 64'd1);
    chk("st_wrap_data", rd, 64'd0);
    d_txn("ld_top", 1'b0, MEM_BYTES - 8, 64'h0, 0, rd, er);
    chk("ld_top_data", rd, 64'h1122334455667788);
    d_txn("ld_0", 1'b0, 32'h0, 64'h0, 0, rd, er);
    chk("ld_0_data", rd, 64'hA1A2A3A4A5A6A7A8);
    f_txn("f_top", MEM_BYTES - 4, frd, fer);
    chk("f_top_res", 64'({fer, frd}), 64'h0_55667788);
    f_txn("f_over", MEM_BYTES - 3, frd, fer);
    chk("f_over_res", 64'({fer, frd}), 64'h1_00000000);

    // back-pressure on the data response
    d_txn("ld_hold", 1'b0, 32'h100, 64'h0, 5, rd, er);
    chk("ld_hold_data", rd, 64'h0123456789ABCDEF);

    // same-edge fetch and store: fetch sees old bytes
    d_txn("st200", 1'b1, 32'h200, 64'hDEADBEEF00000000, 0, rd, er);
    fork
      f_txn("f200_old", 32'h200, frd, fer);
      d_txn("st200_ff", 1'b1, 32'h200, 64'hFFFFFFFFFFFFFFFF, 0, rd, er);
    join
    chk("f200_old_data", 64'(frd), 64'hDEADBEEF);
    chk("st200_ff_data", rd, 64'd0);
    f_txn("f200_new", 32'h200, frd, fer);
    chk("f200_new_data", 64'(frd), 64'hFFFFFFFF);

    // reset while a store is in WAIT: response dropped, write kept
    d_req_valid = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 64'hCAFEF00D12345678;
    d_resp_ready = 1'b1;
    @(negedge clk);
    d_req_valid = 1'b0;
    chk("rw_state", 64'(o_d_state), 64'd1);
    reset = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen |= d_resp_valid;
      chk("rw_ready", 64'({f_req_ready, d_req_ready}), 64'b00);
    end
    reset = 1'b0;
    @(negedge clk);
    seen |= d_resp_valid;
    chk("rw_ready_after", 64'({f_req_ready, d_req_ready}), 64'b11);
    repeat (3) begin @(negedge clk); seen |= d_resp_valid; end
    chk("rw_no_resp", 64'(seen), 64'd0);
    d_resp_ready = 1'b0;
    d_txn("ld300", 1'b0, 32'h300, 64'h0, 0, rd, er);
    chk("ld300_data", rd, 64'hCAFEF00D12345678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
